// File: rtl/instr_loader_if.sv
// Byte-serial program load channel (valid/ready handshake).
//   in_data  : program byte, MSB-first within each 32-bit word
//   in_valid : in_data is valid
//   in_ready : loader will accept a byte; transfer when valid && ready at clk rise
interface instr_loader_if;
   localparam int unsigned DW = 8;

   logic [DW-1:0] in_data;
   logic          in_valid;
   logic          in_ready;

   modport master (output in_data, output in_valid, input in_ready);
   modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/instr_loader.sv
// Program-load front end: assembles a byte-serial image (length byte followed
// by big-endian words) into an instruction store, then serves the core's fetch
// stage through a registered read port.
//   clk, rst_n  : clock, asynchronous active-low reset
//   bus         : byte load channel (slave side)
//   clear       : synchronous discard of the program, back to IDLE
//   fetch_addr  : word address (core pc)
//   fetch_data  : registered instruction word, 0 when no valid program/address
//   prog_valid  : program fully loaded
//   prog_len    : number of loaded words
//   err         : bad length byte received
module instr_loader #(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned AW    = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   instr_loader_if.slave     bus,
   input  logic              clear,
   input  logic [AW-1:0]     fetch_addr,
   output logic [31:0]       fetch_data,
   output logic              prog_valid,
   output logic [AW:0]       prog_len,
   output logic              err
);

   localparam int unsigned WW = 32;
   localparam int unsigned IW = AW + 1;

   typedef enum logic [1:0] {IDLE, LOAD, READY, ERR} state_t;

   state_t          state, state_nxt;
   logic [IW-1:0]   n_len, n_nxt;
   logic [IW-1:0]   word_idx, widx_nxt;
   logic [1:0]      byte_idx, bidx_nxt;
   logic [23:0]     hold, hold_nxt;
   logic            in_ready_q, in_ready_nxt;
   logic            prog_valid_nxt, err_nxt;
   logic [IW-1:0]   prog_len_nxt;
   logic            accept_c;
   logic            we_c;
   logic [WW-1:0]   wdata_c;
   logic [WW-1:0]   fetch_nxt;
   logic [WW-1:0]   mem [0:DEPTH-1];

   assign bus.in_ready = in_ready_q;

   // Next-state, datapath and registered-output next values.
   always_comb begin
      state_nxt = state;
      n_nxt     = n_len;
      widx_nxt  = word_idx;
      bidx_nxt  = byte_idx;
      hold_nxt  = hold;
      we_c      = 1'b0;
      wdata_c   = {hold, bus.in_data};
      accept_c  = bus.in_valid && in_ready_q;

      if (clear) begin
         // clear beats a simultaneous handshake; the byte is dropped
         state_nxt = IDLE;
         widx_nxt  = '0;
         bidx_nxt  = '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept_c) begin
                  if ((32'(bus.in_data) >= 32'd1) && (32'(bus.in_data) <= DEPTH)) begin
                     n_nxt     = IW'(bus.in_data);
                     widx_nxt  = '0;
                     bidx_nxt  = '0;
                     state_nxt = LOAD;
                  end else begin
                     state_nxt = ERR;
                  end
               end
            end
            LOAD: begin
               if (accept_c) begin
                  bidx_nxt = byte_idx + 2'd1;
                  hold_nxt = {hold[15:0], bus.in_data};
                  if (byte_idx == 2'd3) begin
                     we_c     = 1'b1;
                     widx_nxt = word_idx + IW'(1);
                     if (widx_nxt == n_len) begin
                        state_nxt = READY;
                     end
                  end
               end
            end
            default: begin
            end
         endcase
      end

      in_ready_nxt   = (state_nxt == IDLE) || (state_nxt == LOAD);
      prog_valid_nxt = (state_nxt == READY);
      prog_len_nxt   = (state_nxt == READY) ? n_nxt : '0;
      err_nxt        = (state_nxt == ERR);
   end

   // State and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         n_len      <= '0;
         word_idx   <= '0;
         byte_idx   <= '0;
         hold       <= '0;
         in_ready_q <= 1'b1;
         prog_valid <= 1'b0;
         prog_len   <= '0;
         err        <= 1'b0;
      end else begin
         state      <= state_nxt;
         n_len      <= n_nxt;
         word_idx   <= widx_nxt;
         byte_idx   <= bidx_nxt;
         hold       <= hold_nxt;
         in_ready_q <= in_ready_nxt;
         prog_valid <= prog_valid_nxt;
         prog_len   <= prog_len_nxt;
         err        <= err_nxt;
      end
   end

   // Instruction store; only complete words are written.
   always_ff @(posedge clk) begin
      if (we_c) begin
         mem[word_idx[AW-1:0]] <= wdata_c;
      end
   end

   // Registered fetch port; out-of-range or not-loaded reads return a NOP (0).
   always_comb begin
      fetch_nxt = '0;
      if ((state == READY) && ({1'b0, fetch_addr} < prog_len)) begin
         fetch_nxt = mem[fetch_addr];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_data <= '0;
      end else begin
         fetch_data <= fetch_nxt;
      end
   end

endmodule
